// File: rtl/mobo_arbiter.sv
// mobo_arbiter: round-robin two-requester arbiter in front of the single motherboard memory port
module mobo_arbiter #(
  parameter int word_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] req0_ctrl,
  output logic [word_width-1:0] req0_stat,
  input  logic [word_width-1:0] req0_addr,
  input  logic [word_width-1:0] req0_wdat,
  output logic [word_width-1:0] req0_rdat,
  input  logic [word_width-1:0] req1_ctrl,
  output logic [word_width-1:0] req1_stat,
  input  logic [word_width-1:0] req1_addr,
  input  logic [word_width-1:0] req1_wdat,
  output logic [word_width-1:0] req1_rdat,
  output logic [word_width-1:0] mobo_ctrl,
  input  logic [word_width-1:0] mobo_stat,
  output logic [word_width-1:0] addr_out,
  output logic [word_width-1:0] mobodat_out,
  input  logic [word_width-1:0] mobodat_in,
  output logic [1:0]            grant
);
  localparam logic [word_width-1:0] CTRL_NONE  = '0;
  localparam logic [word_width-1:0] CTRL_READ  = word_width'(1);
  localparam logic [word_width-1:0] CTRL_WRITE = word_width'(2);
  localparam logic [word_width-1:0] STAT_IDLE  = '0;
  localparam logic [word_width-1:0] STAT_BUSY  = word_width'(1);
  localparam logic [word_width-1:0] STAT_DONE  = word_width'(2);
  typedef enum logic [1:0] {A_IDLE, A_ISSUE, A_DONE} state_t;
  state_t state_q, state_d;
  logic [word_width-1:0] mobo_ctrl_q, mobo_ctrl_d, addr_q, addr_d, wdat_q, wdat_d;
  logic [word_width-1:0] rdat0_q, rdat0_d, rdat1_q, rdat1_d, stat0_q, stat0_d, stat1_q, stat1_d;
  logic [word_width-1:0] own_stat, own_ctrl;
  logic [1:0] grant_q, grant_d;
  logic last_q, last_d, req0, req1, sel, own;
  assign req0 = req0_ctrl == CTRL_READ || req0_ctrl == CTRL_WRITE;
  assign req1 = req1_ctrl == CTRL_READ || req1_ctrl == CTRL_WRITE;
  assign sel = req0 && req1 ? !last_q : req1;
  assign own = grant_q[1];
  assign own_ctrl = own ? req1_ctrl : req0_ctrl;
  // mobo_ctrl_q doubles as the latched op: it equals op for the whole issue phase
  always_comb begin
    state_d = state_q;
    mobo_ctrl_d = mobo_ctrl_q;
    addr_d = addr_q;
    wdat_d = wdat_q;
    rdat0_d = rdat0_q;
    rdat1_d = rdat1_q;
    grant_d = grant_q;
    last_d = last_q;
    own_stat = STAT_BUSY;
    stat0_d = req0 ? STAT_BUSY : STAT_IDLE;
    stat1_d = req1 ? STAT_BUSY : STAT_IDLE;
    case (state_q)
      A_IDLE: if (mobo_stat == STAT_IDLE && (req0 || req1)) begin
        state_d = A_ISSUE;
        grant_d = sel ? 2'b10 : 2'b01;
        mobo_ctrl_d = sel ? req1_ctrl : req0_ctrl;
        addr_d = sel ? req1_addr : req0_addr;
        wdat_d = sel ? req1_wdat : req0_wdat;
      end
      A_ISSUE: if (mobo_stat == STAT_DONE) begin
        state_d = A_DONE;
        own_stat = STAT_DONE;
        mobo_ctrl_d = CTRL_NONE;
        last_d = own;
        rdat0_d = mobo_ctrl_q == CTRL_READ && !own ? mobodat_in : rdat0_q;
        rdat1_d = mobo_ctrl_q == CTRL_READ && own ? mobodat_in : rdat1_q;
      end
      default: begin
        own_stat = STAT_DONE;
        if (own_ctrl == CTRL_NONE && mobo_stat == STAT_IDLE) begin
          state_d = A_IDLE;
          own_stat = STAT_IDLE;
          grant_d = 2'b00;
        end
      end
    endcase
    if (state_q != A_IDLE) begin
      stat0_d = own ? stat0_d : own_stat;
      stat1_d = own ? own_stat : stat1_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= A_IDLE;
      mobo_ctrl_q <= CTRL_NONE;
      addr_q <= '0;
      wdat_q <= '0;
      rdat0_q <= '0;
      rdat1_q <= '0;
      stat0_q <= STAT_IDLE;
      stat1_q <= STAT_IDLE;
      grant_q <= 2'b00;
      last_q <= 1'b1;
    end else begin
      state_q <= state_d;
      mobo_ctrl_q <= mobo_ctrl_d;
      addr_q <= addr_d;
      wdat_q <= wdat_d;
      rdat0_q <= rdat0_d;
      rdat1_q <= rdat1_d;
      stat0_q <= stat0_d;
      stat1_q <= stat1_d;
      grant_q <= grant_d;
      last_q <= last_d;
    end
  end
  assign mobo_ctrl = mobo_ctrl_q;
  assign addr_out = addr_q;
  assign mobodat_out = wdat_q;
  assign req0_rdat = rdat0_q;
  assign req1_rdat = rdat1_q;
  assign req0_stat = stat0_q;
  assign req1_stat = stat1_q;
  assign grant = grant_q;
endmodule
